// File: rtl/ahb_lite_rr_master.sv
// ahb_lite_rr_master: shares one AHB-Lite master port among N_REQ request/response clients.
// One single-beat NONSEQ transfer is in flight at a time. Grants rotate round-robin, and the
// completion (read data, error flag) is returned to the client that issued the transfer.
module ahb_lite_rr_master #(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                        aclk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ-1:0]            req_write,
    input  logic [N_REQ*3-1:0]          req_size,
    input  logic [N_REQ*32-1:0]         req_wdata,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [31:0]                 rsp_rdata,
    output logic                        rsp_err,
    output logic [ADDR_WIDTH-1:0]       haddr,
    output logic [2:0]                  hburst,
    output logic                        hmastlock,
    output logic [3:0]                  hprot,
    output logic [2:0]                  hsize,
    output logic [1:0]                  htrans,
    output logic [31:0]                 hwdata,
    output logic                        hwrite,
    input  logic [31:0]                 hrdata,
    input  logic                        hready,
    input  logic                        hresp
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IDX_W-1:0]       r_last_grant;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   r_write;
    logic [2:0]             r_size;
    logic [31:0]            r_wdata;
    logic [N_REQ-1:0]       r_rsp_valid;
    logic [31:0]            r_rsp_rdata;
    logic                   r_rsp_err;

    logic                   w_any_valid;
    logic                   w_accept;
    logic                   w_done;
    logic [IDX_W-1:0]       w_grant;
    logic                   w_found;
    int unsigned            w_idx;

    // Per-client views of the flattened request buses.
    logic [ADDR_WIDTH-1:0]  w_addr_arr  [N_REQ];
    logic [2:0]             w_size_arr  [N_REQ];
    logic [31:0]            w_wdata_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign w_addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_size_arr[i]  = req_size[i*3 +: 3];
        assign w_wdata_arr[i] = req_wdata[i*32 +: 32];
    end

    assign w_any_valid = |req_valid;
    // Requests are only taken in IDLE, and never while reset is held.
    assign w_accept    = (r_state == StIdle) && w_any_valid && !reset;
    assign w_done      = (r_state == StData) && hready;

    // Round-robin pick: first valid client after r_last_grant, wrapping modulo N_REQ.
    always_comb begin
        w_grant = r_last_grant;
        w_found = 1'b0;
        w_idx   = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_idx = (32'(r_last_grant) + k) % N_REQ;
            if (!w_found && req_valid[IDX_W'(w_idx)]) begin
                w_found = 1'b1;
                w_grant = IDX_W'(w_idx);
            end
        end
    end

    // FSM next state plus the state-decoded outputs (htrans, accept strobe).
    always_comb begin
        w_state_nxt = r_state;
        htrans      = HTRANS_IDLE;
        req_ready   = '0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    req_ready[w_grant] = 1'b1;
                    w_state_nxt        = StAddr;
                end
            end
            StAddr: begin
                htrans = HTRANS_NONSEQ;
                if (hready) begin
                    w_state_nxt = StData;
                end
            end
            StData: begin
                if (hready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the granted request; the latch drives the bus for the whole transfer.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_last_grant <= IDX_W'(N_REQ - 1);
            r_addr       <= '0;
            r_write      <= 1'b0;
            r_size       <= '0;
            r_wdata      <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_grant;
            r_addr       <= w_addr_arr[w_grant];
            r_write      <= req_write[w_grant];
            r_size       <= w_size_arr[w_grant];
            r_wdata      <= w_wdata_arr[w_grant];
        end
    end

    // Capture the completing data phase and pulse rsp_valid to the issuing client.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            if (w_done) begin
                // r_last_grant only moves on accept, so it still names the issuer here.
                r_rsp_valid[r_last_grant] <= 1'b1;
                r_rsp_rdata               <= hrdata;
                r_rsp_err                 <= hresp;
            end
        end
    end

    assign haddr     = r_addr;
    assign hwrite    = r_write;
    assign hsize     = r_size;
    assign hwdata    = r_wdata;
    assign hburst    = 3'b000;
    assign hmastlock = 1'b0;
    assign hprot     = 4'b0011;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    // A waiting client must keep req_valid high until it sees req_ready.
    a_valid_held: assert property (@(posedge aclk) disable iff (reset)
        !$past(reset) |-> (($past(req_valid) & ~$past(req_ready) & ~req_valid) == '0));

    // Only byte, halfword and word transfers are supported.
    a_size_legal: assert property (@(posedge aclk) disable iff (reset)
        w_accept |-> (w_size_arr[w_grant] <= 3'd2));

endmodule

// File: doc/ahb_lite_rr_master.md
# ahb_lite_rr_master

Round-robin sequencer that shares a single AHB-Lite master port among N_REQ simple request/response clients. It issues one single-beat NONSEQ transfer at a time, handles wait states and the two-cycle ERROR response, and returns read data and error status to the client that issued the transfer. It drives the master side of an `ahb_lite_interface` bus, replacing ad-hoc per-client AHB logic in the register/peripheral fabric.

## Interface
Parameters:
- N_REQ, 2, number of clients (1..8)
- ADDR_WIDTH, 32, haddr width

Ports:
- aclk  in  1  bus clock; everything is on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  client i has a transfer pending; held until accepted
- req_ready  out  N_REQ  one-hot; accept strobe for client i
- req_addr  in  N_REQ*ADDR_WIDTH  client i address at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_write  in  N_REQ  1 = write
- req_size  in  N_REQ*3  hsize encoding; only 0..2 are legal
- req_wdata  in  N_REQ*32  write data; lanes already replicated by the client
- rsp_valid  out  N_REQ  one-cycle, one-hot completion pulse to the issuing client
- rsp_rdata  out  32  read data, valid with rsp_valid
- rsp_err  out  1  1 = slave returned ERROR, valid with rsp_valid
- haddr  out  ADDR_WIDTH, hburst out 3, hmastlock out 1, hprot out 4, hsize out 3, htrans out 2, hwdata out 32, hwrite out 1: AHB-Lite master outputs
- hrdata  in  32, hready in 1, hresp in 1: AHB-Lite master inputs

## Operation
- Constant outputs: hburst = 3'b000 (SINGLE), hmastlock = 0, hprot = 4'b0011.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - htrans = IDLE (2'b00).
  - If any req_valid is high, select grant g by round-robin: the first valid index after last_grant, wrapping modulo N_REQ.
  - Assert req_ready[g] combinationally in that same cycle.
  - Latch addr, write, size and wdata of client g; set last_grant = g; go to ADDR.
- ADDR:
  - htrans = NONSEQ (2'b10); haddr, hwrite and hsize are driven from the latch.
  - All address-phase outputs are held stable while hready = 0.
  - When hready = 1, go to DATA.
- DATA:
  - htrans = IDLE; hwdata is driven from the latch and held for the whole data phase (also on reads).
  - When hready = 1:
    - Register hrdata and hresp into rsp_rdata and rsp_err.
    - Pulse rsp_valid[g] in the next cycle.
    - Go to IDLE.
- ERROR response: the first cycle (hresp = 1, hready = 0) is treated as a wait state. Completion is taken on the second cycle (hresp = 1, hready = 1), so rsp_err = 1.
- last_grant resets to N_REQ-1, so client 0 has first priority after reset.
- last_grant updates only on accept.
- No new request is accepted until the current transfer completes: one outstanding transfer at most.
- req_ready is 0 in ADDR and DATA.
- A client may not drop req_valid before it sees req_ready. If it does, the behaviour is unspecified; assertions flag it.
- rsp_rdata keeps its last value between responses.
- Write responses also update rsp_rdata with hrdata; clients ignore it.

## Timing
- Reset values (every output): htrans = 00, haddr = 0, hwrite = 0, hsize = 0, hwdata = 0, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0; FSM = IDLE.
- Zero wait states:
  - accept at cycle T (IDLE);
  - NONSEQ at T+1;
  - data phase at T+2;
  - rsp_valid at T+3;
  - next accept possible at T+3.
  - Sustained rate is one transfer per 3 cycles.
- Each slave wait cycle adds one cycle of latency in whichever phase it occurs.
- Reset asserted mid-transfer: state goes to IDLE at the next edge and htrans = IDLE from then on. The in-flight transfer produces no rsp_valid, and last_grant returns to N_REQ-1.
- Simultaneous rsp_valid and a new accept in the same cycle is legal and expected.

## Test plan
- Single read, client 0, addr 0x40, zero wait, hrdata = 0xDEADBEEF:
  - htrans = NONSEQ one cycle after req_ready[0];
  - rsp_valid[0] 3 cycles after accept, with rsp_rdata = 0xDEADBEEF and rsp_err = 0.
- Write, client 1, addr 0x104, wdata 0x12345678, hready low for 2 cycles in the data phase:
  - hwdata is stable for all 3 data cycles;
  - rsp_valid[1] comes 5 cycles after accept.
- N_REQ = 2, both clients continuously valid for 6 transfers: grants alternate 0,1,0,1,0,1 and the first grant goes to 0.
- Slave ERROR on a read (hresp = 1/hready = 0, then hresp = 1/hready = 1): rsp_err = 1 with rsp_valid, and the FSM is back in IDLE.
- hready = 0 for 3 cycles during ADDR: haddr, htrans, hwrite and hsize are unchanged across all 3 cycles.
- Reset asserted during DATA: no rsp_valid pulse; htrans = 00 from the next cycle; after reset the first grant goes to client 0 even if client 1 is also valid.
